// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, reset PC default,
// and RV32 major opcodes consumed by the control unit.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_BR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/pc_npc.sv
// Next-PC select: sequential pc+4 (wraps mod 2^32) or word-aligned redirect target.
module pc_npc (
    input  logic [31:0] pc,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] npc
);

    assign npc = sel_target ? {target[31:2], 2'b00} : pc + 32'd4;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: fetches one word per FETCH/ISSUE pair and parks in
// WAIT_BR while the control unit holds the PC for a branch or jump.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        halt_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        pc_valid
);

    fetch_state_e state, next_state;
    logic         pc_load;
    logic         sel_target;
    logic         inst_load;
    logic         pc_resolved;
    logic [31:0]  npc;

    pc_npc u_npc (
        .pc         (pc),
        .sel_target (sel_target),
        .target     (br_target),
        .npc        (npc)
    );

    always_comb begin
        next_state  = state;
        pc_load     = 1'b0;
        sel_target  = 1'b0;
        inst_load   = 1'b0;
        pc_resolved = 1'b0;
        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_load  = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (halt_pc) begin
                    next_state = ST_WAIT_BR;
                end else begin
                    pc_load    = 1'b1;
                    next_state = ST_FETCH;
                end
            end
            ST_WAIT_BR: begin
                if (br_valid) begin
                    pc_load     = 1'b1;
                    sel_target  = br_taken;
                    pc_resolved = 1'b1;
                    next_state  = ST_FETCH;
                end
            end
            default: next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            pc_valid   <= 1'b0;
        end else begin
            state      <= next_state;
            inst_valid <= inst_load;
            pc_valid   <= pc_resolved;
            if (pc_load) begin
                pc <= npc;
            end
            if (inst_load) begin
                inst <= imem_rdata;
            end
        end
    end

    // Request is gated by rst so it is low during reset even before state settles.
    assign imem_req  = (state == ST_FETCH) && !rst;
    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected (pc, inst) and
// redirect PCs into queues; a monitor pops them when the DUT presents them.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        halt_pc;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        pc_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] inst_q[$];
    logic [31:0] pcv_q[$];

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .halt_pc    (halt_pc),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_valid   (pc_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst === 1'b0 && inst_valid === 1'b1) begin
            if (inst_q.size() == 0) begin
                check("unexpected_inst_valid", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = inst_q.pop_front();
                check("issue_pc", pc, e[63:32]);
                check("issue_inst", inst, e[31:0]);
            end
        end
        if (rst === 1'b0 && pc_valid === 1'b1) begin
            if (pcv_q.size() == 0) begin
                check("unexpected_pc_valid", 32'd1, 32'd0);
            end else begin
                logic [31:0] ep;
                ep = pcv_q.pop_front();
                check("redirect_pc", pc, ep);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word,
                            input int stall, input logic halt, input logic spurious);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < stall; i++) begin
            imem_ack = 1'b0;
            if (spurious && i == 0) begin
                br_valid  = 1'b1;
                br_taken  = 1'b1;
                br_target = 32'h0000_0100;
            end
            @(negedge clk);
            br_valid = 1'b0;
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, exp_pc);
            check("stall_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        halt_pc    = halt;
        inst_q.push_back({exp_pc, word});
        @(negedge clk);
        imem_ack = 1'b0;
        check("issue_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        halt_pc = 1'b0;
    endtask

    task automatic do_branch(input int wait_cycles, input logic taken,
                             input logic [31:0] target, input logic [31:0] hold_pc,
                             input logic [31:0] exp_pc);
        for (int i = 0; i < wait_cycles; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd0);
            check("wait_addr", imem_addr, hold_pc);
            check("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        br_valid  = 1'b1;
        br_taken  = taken;
        br_target = target;
        pcv_q.push_back(exp_pc);
        @(negedge clk);
        br_valid = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        check("pc_valid_single", {31'd0, pc_valid}, 32'd0);
    endtask

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ  = 32'h0000_0063;

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; halt_pc = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
        rst = 1'b0;
        #1;

        // Sequential fetch, ack in the first FETCH cycle.
        do_fetch(32'h0, ADDI, 0, 1'b0, 1'b0);
        do_fetch(32'h4, ADDI | 32'h0000_0100, 0, 1'b0, 1'b0);
        do_fetch(32'h8, ADDI | 32'h0000_0200, 0, 1'b0, 1'b0);
        do_fetch(32'hC, ADDI | 32'h0000_0300, 0, 1'b0, 1'b0);

        // Taken branch with misaligned target.
        do_fetch(32'h10, BEQ, 0, 1'b1, 1'b0);
        do_branch(2, 1'b1, 32'h43, 32'h10, 32'h40);
        do_fetch(32'h40, BEQ | 32'h0000_0080, 0, 1'b1, 1'b0);
        do_branch(1, 1'b1, 32'h20, 32'h40, 32'h20);

        // Not-taken branch.
        do_fetch(32'h20, BEQ | 32'h0000_0100, 0, 1'b1, 1'b0);
        do_branch(0, 1'b0, 32'h500, 32'h20, 32'h24);

        // Reset in WAIT_BR with br_valid in the same cycle.
        do_fetch(32'h24, BEQ | 32'h0000_0200, 1, 1'b1, 1'b0);
        rst = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        @(negedge clk);
        check("midrst_req_low", {31'd0, imem_req}, 32'd0);
        rst = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("midrst_req", {31'd0, imem_req}, 32'd1);

        // Memory stall of 5 cycles.
        do_fetch(32'h0, ADDI | 32'h0000_0400, 5, 1'b0, 1'b0);
        do_fetch(32'h4, BEQ | 32'h0000_0300, 0, 1'b1, 1'b0);
        do_branch(0, 1'b1, 32'hFFFF_FFFF, 32'h4, 32'hFFFF_FFFC);

        // Wrap with a spurious br_valid during FETCH.
        do_fetch(32'hFFFF_FFFC, ADDI | 32'h0000_0500, 2, 1'b0, 1'b1);
        do_fetch(32'h0, ADDI | 32'h0000_0600, 0, 1'b0, 1'b0);

        check("inst_q_drained", inst_q.size(), 32'd0);
        check("pcv_q_drained", pcv_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
